// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
//   Groups the two handshake sides seen by fifo_stream_reader:
//     - the read port of a sync_fifo (fifo_empty / fifo_rd / fifo_dout)
//     - the outgoing valid/ready byte stream (m_valid / m_data / m_ready)
//
//   Stream handshake: a byte moves on a rising clk edge where m_valid=1 and
//   m_ready=1. Once m_valid is raised, m_valid and m_data hold until that
//   transfer happens. m_ready may change freely, and m_valid never depends
//   on it.
//
//   Modports
//     master : the drain engine (drives fifo_rd, m_valid, m_data)
//     slave  : the environment, i.e. the FIFO plus the stream consumer
//
//   Parameters
//     DATA_W : width of the FIFO read data and the stream data
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_dout;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//   Read-side drain engine for sync_fifo. It pops bytes through the FIFO
//   read port and allows for the FIFO's one-cycle registered read latency.
//   It presents those bytes on a valid/ready stream through a 2-entry output
//   buffer, so one byte per cycle is sustained under backpressure.
//
//   Ports
//     clk      in   system clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     enable   in   1 = new FIFO reads may be issued
//     bus      if   fifo_stream_reader_if.master
//                     (fifo_empty, fifo_rd, fifo_dout, m_valid, m_data, m_ready)
//     xfer_cnt out  completed stream handshakes, wraps modulo 2^CNT_W
//     occ      out  debug: output buffer occupancy (0..2)
//     inflight out  debug: a FIFO read was issued last cycle and is owed
//
//   Parameters
//     DATA_W   width of FIFO read data and stream data
//     CNT_W    width of the transfer counter
//
//   Reset discards any byte already popped from the FIFO. sync_fifo must
//   therefore share this reset domain.
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              enable,
    fifo_stream_reader_if.master   bus,
    output logic [CNT_W-1:0]       xfer_cnt,
    output logic [1:0]             occ,
    output logic                   inflight
);

    // Registered state
    logic [1:0]        occ_q;
    logic              inflight_q;
    logic [DATA_W-1:0] buf0_q;
    logic [DATA_W-1:0] buf1_q;
    logic [CNT_W-1:0]  cnt_q;

    // Next-state / combinational helpers
    logic [1:0]        occ_d;
    logic [DATA_W-1:0] buf0_d;
    logic [DATA_W-1:0] buf1_d;
    logic              pop;
    logic [1:0]        level;
    logic [1:0]        cap_idx;
    logic              rd;

    // Stream outputs come from registers only, so m_ready never feeds
    // m_valid or m_data.
    assign bus.m_valid = (occ_q != 2'd0);
    assign bus.m_data  = buf0_q;
    assign pop         = bus.m_valid & bus.m_ready;

    // Bytes that will sit in the buffer after this edge if no new read
    // is issued: current entries plus the owed byte, minus the one leaving.
    // pop implies occ_q >= 1, so this cannot underflow. occ_q + inflight_q
    // never exceeds 2, so it fits in 2 bits.
    assign level = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    // A new read is allowed only if its byte is sure to have a slot when it
    // arrives next cycle. rst_n gates the strobe so the FIFO is never popped
    // while this block is held in reset.
    assign rd          = rst_n & enable & ~bus.fifo_empty & (level <= 2'd1);
    assign bus.fifo_rd = rd;

    // Slot index for an arriving byte: the first free slot after this
    // edge's pop has shifted the buffer.
    assign cap_idx = occ_q - {1'b0, pop};

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q - {1'b0, pop} + {1'b0, inflight_q};

        // Shift the buffer on pop. buf1 keeps its stale copy; occ says it
        // is empty.
        if (pop) begin
            buf0_d = buf1_q;
        end

        // The capture wins over the shift when both target buf0.
        if (inflight_q) begin
            if (cap_idx == 2'd0) begin
                buf0_d = bus.fifo_dout;
            end else begin
                buf1_d = bus.fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= rd;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            if (pop) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign xfer_cnt = cnt_q;
    assign occ      = occ_q;
    assign inflight = inflight_q;

`ifndef SYNTHESIS
    // A full buffer with a byte arriving and none leaving would lose data.
    // The read gating above must make this unreachable.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight_q && (occ_q == 2'd2) && !pop));

    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n)
        (occ_q <= 2'd2));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader. The initial block plays the role
//   of a sync_fifo with one-cycle read latency (mem/wr_ptr/rd_ptr) and of the
//   stream consumer. Outputs are sampled on the falling edge. Inputs change
//   1 time unit after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_stream_reader;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

    logic [CNT_W-1:0] xfer_cnt;
    logic [1:0]       occ;
    logic             inflight;

    fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .bus      (bus),
        .xfer_cnt (xfer_cnt),
        .occ      (occ),
        .inflight (inflight)
    );

    // ---------------- FIFO model state ----------------
    logic [DATA_W-1:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Falling-edge samples and running counters
    logic             s_valid;
    logic [DATA_W-1:0] s_data;
    logic             s_rd;
    int rd_cnt   = 0;
    int max_occ  = 0;
    int max_fill = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write a byte into the FIFO model and expect it on the stream.
    task automatic push_byte(input logic [DATA_W-1:0] b);
        mem[wr_ptr % 4096] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    // One clock: sample at negedge, then model the FIFO read at posedge.
    task automatic tick();
        bit rd_pend;
        @(negedge clk);
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_rd    = bus.fifo_rd;
        if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
        rd_pend = bus.fifo_rd;
        if (rd_pend) rd_cnt++;
        if (int'(occ) > max_occ) max_occ = int'(occ);
        if (int'(occ) + int'(inflight) > max_fill) max_fill = int'(occ) + int'(inflight);
        @(posedge clk);
        #1;
        if (rd_pend) begin
            bus.fifo_dout = mem[rd_ptr % 4096];
            rd_ptr++;
        end
    endtask

    task automatic drain(input int n_expect, input int budget, input bit rand_ready);
        int k = 0;
        while (got_q.size() < n_expect && k < budget) begin
            if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        bus.m_ready = 1'b1;
        chk("drain_timeout", got_q.size(), n_expect);
    endtask

    task automatic compare_stream(input string tag);
        int mism = 0;
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
        end
        chk({tag, "_order"}, mism, 0);
    endtask

    initial begin
        int rd0;
        int got0;
        int vseen;

        rst_n         = 1'b0;
        enable        = 1'b1;
        bus.m_ready   = 1'b1;
        bus.fifo_dout = '0;

        // ---------- reset: FIFO holds data, strobe must stay low ----------
        mem[wr_ptr % 4096] = 8'h5A;
        wr_ptr++;
        tick();
        tick();
        chk("rst_fifo_rd", s_rd, 1'b0);
        chk("rst_m_valid", s_valid, 1'b0);
        chk("rst_m_data", s_data, 8'h00);
        chk("rst_xfer_cnt", xfer_cnt, 16'd0);
        chk("rst_occ", occ, 2'd0);
        rd_ptr = wr_ptr;
        rst_n  = 1'b1;
        tick();

        // ---------- test 1: three bytes, free-flowing ----------
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        tick();
        chk("t1_a_rd", s_rd, 1'b1);
        chk("t1_a_valid", s_valid, 1'b0);
        tick();
        chk("t1_b_rd", s_rd, 1'b1);
        chk("t1_b_valid", s_valid, 1'b0);
        tick();
        chk("t1_c_valid", s_valid, 1'b1);
        chk("t1_c_data", s_data, 8'h11);
        chk("t1_c_rd", s_rd, 1'b1);
        tick();
        chk("t1_d_data", s_data, 8'h22);
        chk("t1_d_rd", s_rd, 1'b0);
        tick();
        chk("t1_e_data", s_data, 8'h33);
        tick();
        chk("t1_f_valid", s_valid, 1'b0);
        chk("t1_xfer_cnt", xfer_cnt, 16'd3);
        compare_stream("t1_stream");

        // ---------- test 2: backpressure with 4 bytes queued ----------
        bus.m_ready = 1'b0;
        rd0 = rd_cnt;
        push_byte(8'h44);
        push_byte(8'h55);
        push_byte(8'h66);
        push_byte(8'h77);
        for (int i = 0; i < 6; i++) tick();
        chk("t2_rd_pulses", rd_cnt - rd0, 2);
        chk("t2_occ", occ, 2'd2);
        chk("t2_inflight", inflight, 1'b0);
        chk("t2_hold_valid", s_valid, 1'b1);
        chk("t2_hold_data", s_data, 8'h44);
        bus.m_ready = 1'b1;
        got0 = got_q.size();
        for (int i = 0; i < 4; i++) tick();
        chk("t2_rate", got_q.size() - got0, 4);
        tick();
        chk("t2_idle_valid", s_valid, 1'b0);
        chk("t2_xfer_cnt", xfer_cnt, 16'd7);
        compare_stream("t2_stream");

        // ---------- test 3: empty FIFO, then a single byte ----------
        rd0   = rd_cnt;
        vseen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_valid) vseen++;
        end
        chk("t3_empty_rd", rd_cnt - rd0, 0);
        chk("t3_empty_valid", vseen, 0);
        got0 = got_q.size();
        push_byte(8'hA5);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_one_rd", rd_cnt - rd0, 1);
        chk("t3_one_byte", got_q.size() - got0, 1);
        chk("t3_xfer_cnt", xfer_cnt, 16'd8);
        compare_stream("t3_stream");

        // ---------- test 4: enable drops right after a read ----------
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        got0 = got_q.size();
        tick();
        chk("t4_first_rd", s_rd, 1'b1);
        enable = 1'b0;
        rd0    = rd_cnt;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_no_rd", rd_cnt - rd0, 0);
        chk("t4_inflight_kept", got_q.size() - got0, 1);
        chk("t4_fifo_left", bus.fifo_empty, 1'b0);
        enable = 1'b1;
        drain(got0 + 3, 20, 1'b0);
        tick();
        chk("t4_xfer_cnt", xfer_cnt, 16'd11);
        compare_stream("t4_stream");

        // ---------- test 5: 1000 bytes, random backpressure ----------
        max_occ  = 0;
        max_fill = 0;
        for (int i = 0; i < 1000; i++) push_byte(8'(i % 256));
        drain(exp_q.size(), 6000, 1'b1);
        tick();
        chk("t5_xfer_cnt", xfer_cnt, 16'd1011);
        chk("t5_max_occ_le2", (max_occ <= 2), 1'b1);
        chk("t5_max_fill_le2", (max_fill <= 2), 1'b1);
        compare_stream("t5_stream");

        // ---------- test 6: reset mid-stream with a full buffer ----------
        bus.m_ready = 1'b0;
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        push_byte(8'hC4);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_pre_occ", occ, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.m_valid, 1'b0);
        chk("t6_rst_xfer_cnt", xfer_cnt, 16'd0);
        chk("t6_rst_fifo_rd", bus.fifo_rd, 1'b0);
        tick();
        chk("t6_rst_occ", occ, 2'd0);
        // The FIFO shares the reset: its contents and the buffered bytes go.
        rd_ptr = wr_ptr;
        for (int i = 0; i < 4; i++) void'(exp_q.pop_back());
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        push_byte(8'hD1);
        push_byte(8'hD2);
        push_byte(8'hD3);
        drain(exp_q.size(), 20, 1'b0);
        tick();
        chk("t6_xfer_cnt", xfer_cnt, 16'd3);
        compare_stream("t6_stream");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
